register_rename: RTL and testbench



---
 rtl/register_rename.sv | 171 +++++++++++++++++
 tb/tb_register_rename.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_rename.sv
// Dual-issue register rename: speculative and retirement RATs, intra-group bypass,
// free-list pops and a one-deep output register. Flush restores the speculative map.
module register_rename #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PREG_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  output logic              in_ready,
  input  logic [4:0]        in_src_a_1,
  input  logic [4:0]        in_src_b_1,
  input  logic [4:0]        in_dst_1,
  input  logic              in_wr_1,
  input  logic [4:0]        in_src_a_2,
  input  logic [4:0]        in_src_b_2,
  input  logic [4:0]        in_dst_2,
  input  logic              in_wr_2,
  input  logic [PREG_W-1:0] fl_data_1,
  input  logic [PREG_W-1:0] fl_data_2,
  input  logic              fl_valid_1,
  input  logic              fl_valid_2,
  output logic              fl_pop_1,
  output logic              fl_pop_2,
  output logic              out_valid_1,
  output logic              out_valid_2,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_psrc_a_1,
  output logic [PREG_W-1:0] out_psrc_b_1,
  output logic [PREG_W-1:0] out_pdst_1,
  output logic [PREG_W-1:0] out_pold_1,
  output logic              out_wr_1,
  output logic [PREG_W-1:0] out_psrc_a_2,
  output logic [PREG_W-1:0] out_psrc_b_2,
  output logic [PREG_W-1:0] out_pdst_2,
  output logic [PREG_W-1:0] out_pold_2,
  output logic              out_wr_2,
  input  logic              cmt_valid_1,
  input  logic [4:0]        cmt_arch_1,
  input  logic [PREG_W-1:0] cmt_preg_1,
  input  logic              cmt_valid_2,
  input  logic [4:0]        cmt_arch_2,
  input  logic [PREG_W-1:0] cmt_preg_2,
  input  logic              flush
);

  logic [PREG_W-1:0] spec_q [ARCH_REGS];
  logic [PREG_W-1:0] spec_d [ARCH_REGS];
  logic [PREG_W-1:0] ret_q  [ARCH_REGS];
  logic [PREG_W-1:0] ret_d  [ARCH_REGS];

  logic              wr_eff_1, wr_eff_2, fl_ok, accept;
  logic [1:0]        need;
  logic [PREG_W-1:0] pdst_1, pdst_2;
  logic [PREG_W-1:0] psrc_a_1, psrc_b_1, pold_1, psrc_a_2, psrc_b_2, pold_2;

  logic              valid_1_q, valid_2_q, wr_1_q, wr_2_q;
  logic [PREG_W-1:0] psrc_a_1_q, psrc_b_1_q, pdst_1_q, pold_1_q;
  logic [PREG_W-1:0] psrc_a_2_q, psrc_b_2_q, pdst_2_q, pold_2_q;

  assign wr_eff_1 = in_valid_1 & in_wr_1 & (in_dst_1 != '0);
  assign wr_eff_2 = in_valid_2 & in_wr_2 & (in_dst_2 != '0);
  assign need     = {1'b0, wr_eff_1} + {1'b0, wr_eff_2};

  always_comb begin
    fl_ok = 1'b1;
    case (need)
      2'd1:    fl_ok = fl_valid_1;
      2'd2:    fl_ok = fl_valid_1 & fl_valid_2;
      default: fl_ok = 1'b1;
    endcase
  end

  assign in_ready = ~flush & fl_ok & (~valid_1_q | out_ready);
  assign accept   = in_valid_1 & in_ready;
  assign fl_pop_1 = accept & (need != 2'd0);
  assign fl_pop_2 = accept & (need == 2'd2);

  // A lone writer always takes the head tag, whichever slot it sits in.
  assign pdst_1 = wr_eff_1 ? fl_data_1 : '0;
  assign pdst_2 = wr_eff_2 ? (wr_eff_1 ? fl_data_2 : fl_data_1) : '0;

  assign psrc_a_1 = spec_q[in_src_a_1];
  assign psrc_b_1 = spec_q[in_src_b_1];
  assign pold_1   = wr_eff_1 ? spec_q[in_dst_1] : '0;

  assign psrc_a_2 = (wr_eff_1 && in_src_a_2 == in_dst_1) ? pdst_1 : spec_q[in_src_a_2];
  assign psrc_b_2 = (wr_eff_1 && in_src_b_2 == in_dst_1) ? pdst_1 : spec_q[in_src_b_2];
  assign pold_2   = !wr_eff_2                          ? '0     :
                    (wr_eff_1 && in_dst_2 == in_dst_1) ? pdst_1 : spec_q[in_dst_2];

  always_comb begin
    ret_d = ret_q;
    if (cmt_valid_1 && cmt_arch_1 != '0) ret_d[cmt_arch_1] = cmt_preg_1;
    if (cmt_valid_2 && cmt_arch_2 != '0) ret_d[cmt_arch_2] = cmt_preg_2;
  end

  // Flush restores from the post-commit retirement map so same-cycle commits survive.
  always_comb begin
    spec_d = spec_q;
    if (flush) begin
      spec_d = ret_d;
    end else if (accept) begin
      if (wr_eff_1) spec_d[in_dst_1] = pdst_1;
      if (wr_eff_2) spec_d[in_dst_2] = pdst_2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_q[i] <= PREG_W'(i);
        ret_q[i]  <= PREG_W'(i);
      end
    end else begin
      spec_q <= spec_d;
      ret_q  <= ret_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_1_q  <= 1'b0;
      valid_2_q  <= 1'b0;
      wr_1_q     <= 1'b0;
      wr_2_q     <= 1'b0;
      psrc_a_1_q <= '0;
      psrc_b_1_q <= '0;
      pdst_1_q   <= '0;
      pold_1_q   <= '0;
      psrc_a_2_q <= '0;
      psrc_b_2_q <= '0;
      pdst_2_q   <= '0;
      pold_2_q   <= '0;
    end else if (flush) begin
      valid_1_q <= 1'b0;
      valid_2_q <= 1'b0;
    end else if (accept) begin
      valid_1_q  <= 1'b1;
      valid_2_q  <= in_valid_2;
      wr_1_q     <= wr_eff_1;
      wr_2_q     <= wr_eff_2;
      psrc_a_1_q <= psrc_a_1;
      psrc_b_1_q <= psrc_b_1;
      pdst_1_q   <= pdst_1;
      pold_1_q   <= pold_1;
      psrc_a_2_q <= psrc_a_2;
      psrc_b_2_q <= psrc_b_2;
      pdst_2_q   <= pdst_2;
      pold_2_q   <= pold_2;
    end else if (out_ready) begin
      valid_1_q <= 1'b0;
      valid_2_q <= 1'b0;
    end
  end

  assign out_valid_1  = valid_1_q;
  assign out_valid_2  = valid_2_q;
  assign out_wr_1     = wr_1_q;
  assign out_wr_2     = wr_2_q;
  assign out_psrc_a_1 = psrc_a_1_q;
  assign out_psrc_b_1 = psrc_b_1_q;
  assign out_pdst_1   = pdst_1_q;
  assign out_pold_1   = pold_1_q;
  assign out_psrc_a_2 = psrc_a_2_q;
  assign out_psrc_b_2 = psrc_b_2_q;
  assign out_pdst_2   = pdst_2_q;
  assign out_pold_2   = pold_2_q;

endmodule

// File: tb/tb_register_rename.sv
// Scenario bench for register_rename: a reference rename model pushes expected output
// groups to a queue at accept; each scenario pops and compares once the output register loads.
module tb_register_rename;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_1, in_valid_2, in_ready;
  logic [4:0] in_src_a_1, in_src_b_1, in_dst_1, in_src_a_2, in_src_b_2, in_dst_2;
  logic       in_wr_1, in_wr_2;
  logic [5:0] fl_data_1, fl_data_2;
  logic       fl_valid_1, fl_valid_2, fl_pop_1, fl_pop_2;
  logic       out_valid_1, out_valid_2, out_ready, out_wr_1, out_wr_2;
  logic [5:0] out_psrc_a_1, out_psrc_b_1, out_pdst_1, out_pold_1;
  logic [5:0] out_psrc_a_2, out_psrc_b_2, out_pdst_2, out_pold_2;
  logic       cmt_valid_1, cmt_valid_2;
  logic [4:0] cmt_arch_1, cmt_arch_2;
  logic [5:0] cmt_preg_1, cmt_preg_2;
  logic       flush;

  int checks = 0;
  int errors = 0;

  logic [5:0]  ms [32];
  logic [5:0]  mr [32];
  logic [51:0] sb [$];
  logic [51:0] exp_v;

  always #5 clk = ~clk;

  register_rename dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2), .in_ready(in_ready),
    .in_src_a_1(in_src_a_1), .in_src_b_1(in_src_b_1), .in_dst_1(in_dst_1), .in_wr_1(in_wr_1),
    .in_src_a_2(in_src_a_2), .in_src_b_2(in_src_b_2), .in_dst_2(in_dst_2), .in_wr_2(in_wr_2),
    .fl_data_1(fl_data_1), .fl_data_2(fl_data_2),
    .fl_valid_1(fl_valid_1), .fl_valid_2(fl_valid_2),
    .fl_pop_1(fl_pop_1), .fl_pop_2(fl_pop_2),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2), .out_ready(out_ready),
    .out_psrc_a_1(out_psrc_a_1), .out_psrc_b_1(out_psrc_b_1),
    .out_pdst_1(out_pdst_1), .out_pold_1(out_pold_1), .out_wr_1(out_wr_1),
    .out_psrc_a_2(out_psrc_a_2), .out_psrc_b_2(out_psrc_b_2),
    .out_pdst_2(out_pdst_2), .out_pold_2(out_pold_2), .out_wr_2(out_wr_2),
    .cmt_valid_1(cmt_valid_1), .cmt_arch_1(cmt_arch_1), .cmt_preg_1(cmt_preg_1),
    .cmt_valid_2(cmt_valid_2), .cmt_arch_2(cmt_arch_2), .cmt_preg_2(cmt_preg_2),
    .flush(flush)
  );

  function automatic logic [51:0] pack_out();
    return {out_valid_1, out_valid_2, out_wr_1, out_wr_2,
            out_psrc_a_1, out_psrc_b_1, out_pdst_1, out_pold_1,
            out_psrc_a_2, out_psrc_b_2, out_pdst_2, out_pold_2};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ms[i] = 6'(i);
      mr[i] = 6'(i);
    end
    sb.delete();
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid_1 = 0; in_valid_2 = 0; in_wr_1 = 0; in_wr_2 = 0;
    in_src_a_1 = 0; in_src_b_1 = 0; in_dst_1 = 0;
    in_src_a_2 = 0; in_src_b_2 = 0; in_dst_2 = 0;
    flush = 0; cmt_valid_1 = 0; cmt_valid_2 = 0; out_ready = 1;
    @(posedge clk);
    #1;
  endtask

  // Drives one group at the negedge, checks handshake/pops, pushes the expected output.
  task automatic send(input logic v2,
                      input logic [4:0] s1a, input logic [4:0] s1b, input logic [4:0] d1,
                      input logic w1,
                      input logic [4:0] s2a, input logic [4:0] s2b, input logic [4:0] d2,
                      input logic w2, input logic [5:0] f1, input logic [5:0] f2);
    logic       we1, we2;
    logic [5:0] pd1, pd2, pa1, pb1, po1, pa2, pb2, po2;
    @(negedge clk);
    in_valid_1 = 1; in_valid_2 = v2;
    in_src_a_1 = s1a; in_src_b_1 = s1b; in_dst_1 = d1; in_wr_1 = w1;
    in_src_a_2 = s2a; in_src_b_2 = s2b; in_dst_2 = d2; in_wr_2 = w2;
    fl_data_1 = f1; fl_data_2 = f2; fl_valid_1 = 1; fl_valid_2 = 1;
    flush = 0; cmt_valid_1 = 0; cmt_valid_2 = 0; out_ready = 1;
    we1 = w1 && d1 != 0;
    we2 = v2 && w2 && d2 != 0;
    pd1 = we1 ? f1 : 6'd0;
    pd2 = !we2 ? 6'd0 : (we1 ? f2 : f1);
    pa1 = ms[s1a];
    pb1 = ms[s1b];
    po1 = we1 ? ms[d1] : 6'd0;
    pa2 = (we1 && s2a == d1) ? pd1 : ms[s2a];
    pb2 = (we1 && s2b == d1) ? pd1 : ms[s2b];
    po2 = !we2 ? 6'd0 : ((we1 && d2 == d1) ? pd1 : ms[d2]);
    #1;
    checks++;
    if (in_ready !== 1'b1 || fl_pop_1 !== (we1 | we2) || fl_pop_2 !== (we1 & we2)) begin
      errors++;
      $display("FAIL send_handshake: got ready=%b pop=%b%b, want ready=1 pop=%b%b",
               in_ready, fl_pop_1, fl_pop_2, we1 | we2, we1 & we2);
    end
    sb.push_back({1'b1, v2, we1, we2, pa1, pb1, pd1, po1, pa2, pb2, pd2, po2});
    if (we1) ms[d1] = pd1;
    if (we2) ms[d2] = pd2;
  endtask

  task automatic test_reset();
    rst_n = 0; out_ready = 1; flush = 0;
    in_valid_1 = 0; in_valid_2 = 0; in_wr_1 = 0; in_wr_2 = 0;
    in_src_a_1 = 0; in_src_b_1 = 0; in_dst_1 = 0;
    in_src_a_2 = 0; in_src_b_2 = 0; in_dst_2 = 0;
    fl_data_1 = 0; fl_data_2 = 0; fl_valid_1 = 0; fl_valid_2 = 0;
    cmt_valid_1 = 0; cmt_valid_2 = 0; cmt_arch_1 = 0; cmt_arch_2 = 0;
    cmt_preg_1 = 0; cmt_preg_2 = 0;
    model_reset();
    #12;
    checks++;
    if (pack_out() !== 52'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", pack_out());
    end
    checks++;
    if (in_ready !== 1'b1 || fl_pop_1 !== 1'b0 || fl_pop_2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got ready=%b pops=%b%b want 1 00",
               in_ready, fl_pop_1, fl_pop_2);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single();
    send(0, 5, 6, 5, 1, 0, 0, 0, 0, 6'd32, 6'd33);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    checks++;
    if (pack_out() !== exp_v) begin
      errors++;
      $display("FAIL single_group: got %h want %h", pack_out(), exp_v);
    end
    checks++;
    if ({out_psrc_a_1, out_psrc_b_1, out_pdst_1, out_pold_1} !== {6'd5, 6'd6, 6'd32, 6'd5}) begin
      errors++;
      $display("FAIL single_values: got %0d/%0d/%0d/%0d want 5/6/32/5",
               out_psrc_a_1, out_psrc_b_1, out_pdst_1, out_pold_1);
    end
    idle();
    checks++;
    if (out_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL drain_clears: got out_valid_1=%b want 0", out_valid_1);
    end
  endtask

  task automatic test_back_to_back();
    send(1, 1, 2, 3, 1, 3, 5, 3, 1, 6'd40, 6'd41);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    checks++;
    if (pack_out() !== exp_v) begin
      errors++;
      $display("FAIL dep_pair: got %h want %h", pack_out(), exp_v);
    end
    checks++;
    if ({out_psrc_a_2, out_psrc_b_2, out_pold_2, out_pdst_1, out_pdst_2, out_pold_1} !==
        {6'd40, 6'd32, 6'd40, 6'd40, 6'd41, 6'd3}) begin
      errors++;
      $display("FAIL dep_values: got a2=%0d b2=%0d pold2=%0d pd=%0d/%0d pold1=%0d",
               out_psrc_a_2, out_psrc_b_2, out_pold_2, out_pdst_1, out_pdst_2, out_pold_1);
    end
    send(0, 3, 0, 8, 1, 0, 0, 0, 0, 6'd42, 6'd43);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    checks++;
    if (pack_out() !== exp_v || out_psrc_a_1 !== 6'd41) begin
      errors++;
      $display("FAIL next_reads_r3: got %h (a1=%0d) want %h (a1=41)", pack_out(),
               out_psrc_a_1, exp_v);
    end
    idle();
  endtask

  task automatic test_starve();
    @(negedge clk);
    in_valid_1 = 1; in_valid_2 = 1; in_wr_1 = 1; in_wr_2 = 1;
    in_dst_1 = 10; in_dst_2 = 11; in_src_a_1 = 10; in_src_a_2 = 11;
    fl_data_1 = 6'd45; fl_data_2 = 6'd46; fl_valid_1 = 1; fl_valid_2 = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || fl_pop_1 !== 1'b0 || fl_pop_2 !== 1'b0) begin
      errors++;
      $display("FAIL starve_block: got ready=%b pops=%b%b want 0 00",
               in_ready, fl_pop_1, fl_pop_2);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL starve_no_output: got out_valid_1=%b want 0", out_valid_1);
    end
    send(1, 10, 0, 10, 1, 11, 0, 11, 1, 6'd45, 6'd46);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    checks++;
    if (pack_out() !== exp_v) begin
      errors++;
      $display("FAIL starve_release: got %h want %h", pack_out(), exp_v);
    end
    idle();
  endtask

  task automatic test_backpressure();
    send(0, 1, 2, 4, 1, 0, 0, 0, 0, 6'd47, 6'd48);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    out_ready = 0;
    in_valid_1 = 1; in_wr_1 = 1; in_dst_1 = 9; fl_data_1 = 6'd49;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (pack_out() !== exp_v || in_ready !== 1'b0 || fl_pop_1 !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got %h ready=%b pop=%b want %h ready=0 pop=0", c,
                 pack_out(), in_ready, fl_pop_1, exp_v);
      end
      @(posedge clk); #1;
    end
    idle();
    checks++;
    if (out_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got out_valid_1=%b want 0", out_valid_1);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    cmt_valid_1 = 1; cmt_arch_1 = 9; cmt_preg_1 = 6'd20;
    cmt_valid_2 = 1; cmt_arch_2 = 9; cmt_preg_2 = 6'd21;
    mr[9] = 6'd21;
    @(posedge clk); #1;
    send(0, 0, 0, 7, 1, 0, 0, 0, 0, 6'd50, 6'd51);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    checks++;
    if (pack_out() !== exp_v || out_pdst_1 !== 6'd50) begin
      errors++;
      $display("FAIL flush_pre_rename: got %h want %h", pack_out(), exp_v);
    end
    @(negedge clk);
    out_ready = 0; flush = 1;
    in_valid_1 = 1; in_wr_1 = 1; in_dst_1 = 12;
    cmt_valid_1 = 1; cmt_arch_1 = 7; cmt_preg_1 = 6'd44;
    cmt_valid_2 = 1; cmt_arch_2 = 0; cmt_preg_2 = 6'd55;
    mr[7] = 6'd44;
    #1;
    checks++;
    if (in_ready !== 1'b0 || fl_pop_1 !== 1'b0 || fl_pop_2 !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_accept: got ready=%b pops=%b%b want 0 00",
               in_ready, fl_pop_1, fl_pop_2);
    end
    @(posedge clk); #1;
    ms = mr;
    checks++;
    if (out_valid_1 !== 1'b0 || out_valid_2 !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard: got valid=%b%b want 00", out_valid_1, out_valid_2);
    end
    send(1, 7, 9, 0, 0, 0, 3, 0, 0, 6'd0, 6'd0);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    checks++;
    if (pack_out() !== exp_v ||
        {out_psrc_a_1, out_psrc_b_1, out_psrc_a_2, out_psrc_b_2} !== {6'd44, 6'd21, 6'd0, 6'd3})
    begin
      errors++;
      $display("FAIL flush_restore: got %h (r7=%0d r9=%0d r3=%0d) want %h (44 21 3)",
               pack_out(), out_psrc_a_1, out_psrc_b_1, out_psrc_b_2, exp_v);
    end
    idle();
  endtask

  task automatic test_x0();
    send(1, 0, 5, 0, 1, 0, 4, 6, 1, 6'd56, 6'd57);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    checks++;
    if (pack_out() !== exp_v) begin
      errors++;
      $display("FAIL x0_group: got %h want %h", pack_out(), exp_v);
    end
    checks++;
    if (out_wr_1 !== 1'b0 || out_psrc_a_1 !== 6'd0 || out_pdst_2 !== 6'd56) begin
      errors++;
      $display("FAIL x0_values: got wr1=%b a1=%0d pdst2=%0d want 0 0 56",
               out_wr_1, out_psrc_a_1, out_pdst_2);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    send(0, 0, 0, 12, 1, 0, 0, 0, 0, 6'd60, 6'd61);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    checks++;
    if (pack_out() !== exp_v) begin
      errors++;
      $display("FAIL mid_pre: got %h want %h", pack_out(), exp_v);
    end
    in_valid_1 = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (pack_out() !== 52'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got %h want 0", pack_out());
    end
    @(negedge clk);
    rst_n = 1;
    send(0, 12, 7, 0, 0, 0, 0, 0, 0, 6'd0, 6'd0);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    checks++;
    if (pack_out() !== exp_v || out_psrc_a_1 !== 6'd12 || out_psrc_b_1 !== 6'd7) begin
      errors++;
      $display("FAIL mid_identity: got %h want %h", pack_out(), exp_v);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_starve();
    test_backpressure();
    test_flush();
    test_x0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
